// File: rtl/fetch_splitter.sv
// fetch_splitter: splits 64-bit fetch packets into one 32-bit instr/cycle.
// Optional perf_bubble counter enabled by `define FETCH_SPLIT_PERF_EN.
module fetch_splitter #(
  parameter int PCW = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [63:0]    f_data,
  input  logic [PCW-1:0] f_pc,
  input  logic           f_valid,
  output logic           f_ready,
  output logic [31:0]    d_instr,
  output logic [PCW-1:0] d_pc,
  output logic           d_valid,
  input  logic           d_ready,
`ifdef FETCH_SPLIT_PERF_EN
  output logic [31:0]    perf_bubble,
`endif
  input  logic           flush
);

  logic           hold_q, hold_d;
  logic           slot_q, slot_d;
  logic [63:0]    data_q, data_d;
  logic [PCW-1:4] pc_hi_q, pc_hi_d;
  logic           pc_b3_q, pc_b3_d;
  logic           last;
  logic           load;
  logic           issue;
  logic           kill;
  logic           unused_pc;

  // bits [1:0] of the packet PC carry no information
  assign unused_pc = ^f_pc[1:0];

  assign kill    = rst | flush;
  assign last    = hold_q & slot_q;
  assign d_valid = hold_q & ~kill;
  assign f_ready = ~kill & (~hold_q | (d_ready & last));
  assign load    = f_valid & f_ready;
  assign issue   = d_valid & d_ready;
  assign d_instr = slot_q ? data_q[63:32] : data_q[31:0];
  assign d_pc    = {pc_hi_q, pc_b3_q, slot_q, 2'b00};

  // next-state: kill beats load, load beats issue
  always_comb begin
    hold_d  = hold_q;
    slot_d  = slot_q;
    data_d  = data_q;
    pc_hi_d = pc_hi_q;
    pc_b3_d = pc_b3_q;
    if (kill) begin
      hold_d = 1'b0;
      slot_d = 1'b0;
    end else if (load) begin
      hold_d  = 1'b1;
      data_d  = f_data;
      pc_hi_d = f_pc[PCW-1:4];
      pc_b3_d = f_pc[3];
      slot_d  = f_pc[2];
    end else if (issue) begin
      if (!slot_q) slot_d = 1'b1;
      else         hold_d = 1'b0;
    end
  end

  // control state; reset clears valid and slot index
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= 1'b0;
      slot_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      slot_q <= slot_d;
    end
  end

  // packet payload; only meaningful while hold_q is set
  always_ff @(posedge clk) begin
    data_q  <= data_d;
    pc_hi_q <= pc_hi_d;
    pc_b3_q <= pc_b3_d;
  end

`ifdef FETCH_SPLIT_PERF_EN
  logic [31:0] perf_q, perf_d;
  assign perf_d      = perf_q + 32'd1;
  assign perf_bubble = perf_q;

  // count decoder-ready cycles with nothing to issue
  always_ff @(posedge clk) begin
    if (rst) perf_q <= 32'd0;
    else if (d_ready && !d_valid && !flush) perf_q <= perf_d;
  end
`endif

endmodule

// File: tb/tb_fetch_splitter.sv
// tb_fetch_splitter: directed steps with a queue scoreboard.
// Define FETCH_SPLIT_PERF_EN to also cover the bubble counter.
module tb_fetch_splitter;

  localparam int PCW = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [63:0]    f_data;
  logic [PCW-1:0] f_pc;
  logic           f_valid;
  logic           f_ready;
  logic [31:0]    d_instr;
  logic [PCW-1:0] d_pc;
  logic           d_valid;
  logic           d_ready;
  logic           flush;
`ifdef FETCH_SPLIT_PERF_EN
  logic [31:0]    perf_bubble;
`endif

  typedef struct packed {
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
  } exp_t;

  exp_t sbq[$];
  int   vec = 0;
  int   err = 0;

  always #5 clk = ~clk;

  fetch_splitter #(.PCW(PCW)) dut (
    .clk     (clk),
    .rst     (rst),
    .f_data  (f_data),
    .f_pc    (f_pc),
    .f_valid (f_valid),
    .f_ready (f_ready),
    .d_instr (d_instr),
    .d_pc    (d_pc),
    .d_valid (d_valid),
    .d_ready (d_ready),
`ifdef FETCH_SPLIT_PERF_EN
    .perf_bubble (perf_bubble),
`endif
    .flush   (flush)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard at the settled point of the cycle, then advance one edge
  task automatic cyc();
    exp_t e;
    logic [PCW-1:0] base;
    if (d_valid && d_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", {32'd0, d_instr}, 64'hdead);
      end else begin
        e = sbq.pop_front();
        chk("sb_instr", {32'd0, d_instr}, {32'd0, e.instr});
        chk("sb_pc", d_pc, e.pc);
      end
    end
    if (f_valid && f_ready) begin
      base = {f_pc[PCW-1:3], 3'b000};
      if (!f_pc[2]) begin
        e.instr = f_data[31:0];
        e.pc    = base;
        sbq.push_back(e);
      end
      e.instr = f_data[63:32];
      e.pc    = base | 64'h4;
      sbq.push_back(e);
    end
    if (flush || rst) sbq.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] pd [3];
    logic [63:0] pp [3];
    logic        fr_exp;
    int          idx;

    rst = 1'b1; f_valid = 1'b0; d_ready = 1'b0;
    flush = 1'b0; f_data = '0; f_pc = '0;
    @(posedge clk); #1;
    chk("rst_dvalid", {63'd0, d_valid}, 64'd0);
    chk("rst_fready", {63'd0, f_ready}, 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("empty_dvalid", {63'd0, d_valid}, 64'd0);
    chk("empty_fready", {63'd0, f_ready}, 64'd1);

    // two-slot packet
    d_ready = 1'b1; f_valid = 1'b1;
    f_data = 64'h00200093_00100093; f_pc = 64'h80000000;
    #1;
    chk("t1_fready", {63'd0, f_ready}, 64'd1);
    cyc();
    f_valid = 1'b0;
    #1;
    chk("t1_i0", {32'd0, d_instr}, 64'h00100093);
    chk("t1_pc0", d_pc, 64'h80000000);
    chk("t1_fready_s0", {63'd0, f_ready}, 64'd0);
    cyc();
    chk("t1_i1", {32'd0, d_instr}, 64'h00200093);
    chk("t1_pc1", d_pc, 64'h80000004);
    chk("t1_fready_s1", {63'd0, f_ready}, 64'd1);
    cyc();
    chk("t1_drained", {63'd0, d_valid}, 64'd0);

    // packet entering at slot 1
    f_valid = 1'b1;
    f_data = 64'hAAAA0001_BBBB0002; f_pc = 64'h80000014;
    #1;
    cyc();
    f_valid = 1'b0;
    #1;
    chk("t2_instr", {32'd0, d_instr}, 64'hAAAA0001);
    chk("t2_pc", d_pc, 64'h80000014);
    chk("t2_fready", {63'd0, f_ready}, 64'd1);
    cyc();
    chk("t2_drained", {63'd0, d_valid}, 64'd0);

    // three packets back to back, full throughput
    pd[0] = 64'h11110002_11110001; pp[0] = 64'h1000;
    pd[1] = 64'h22220002_22220001; pp[1] = 64'h1008;
    pd[2] = 64'h33330002_33330001; pp[2] = 64'h1010;
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      f_valid = (idx < 3);
      if (idx < 3) begin
        f_data = pd[idx];
        f_pc   = pp[idx];
      end
      #1;
      if (c < 6) begin
        fr_exp = (c % 2 == 0);
        chk("t3_fready", {63'd0, f_ready}, {63'd0, fr_exp});
      end
      if (c >= 1) begin
        chk("t3_dvalid", {63'd0, d_valid}, 64'd1);
        chk("t3_pc", d_pc, 64'h1000 + 64'(4 * (c - 1)));
      end
      if (f_valid && f_ready) idx++;
      cyc();
    end
    f_valid = 1'b0;
    #1;
    chk("t3_drained", {63'd0, d_valid}, 64'd0);

    // stall while slot 1 held
    f_valid = 1'b1; f_data = 64'h44440002_44440001; f_pc = 64'h2000;
    #1;
    cyc();
    f_valid = 1'b0;
    #1;
    cyc();
    d_ready = 1'b0; f_valid = 1'b1;
    f_data = 64'h55550002_55550001; f_pc = 64'h3000;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_instr", {32'd0, d_instr}, 64'h44440002);
      chk("t4_pc", d_pc, 64'h2004);
      chk("t4_dvalid", {63'd0, d_valid}, 64'd1);
      chk("t4_fready", {63'd0, f_ready}, 64'd0);
      cyc();
    end
    d_ready = 1'b1;
    #1;
    chk("t4_release_fready", {63'd0, f_ready}, 64'd1);
    cyc();
    f_valid = 1'b0;
    #1;
    chk("t4_next_pc", d_pc, 64'h3000);
    chk("t4_next_instr", {32'd0, d_instr}, 64'h55550001);
    cyc();
    cyc();

    // flush with slot 0 held and upstream valid
    d_ready = 1'b0; f_valid = 1'b1;
    f_data = 64'h66660002_66660001; f_pc = 64'h4000;
    #1;
    cyc();
    flush = 1'b1; d_ready = 1'b1;
    f_data = 64'h77770002_77770001; f_pc = 64'h5000;
    #1;
    chk("t5_flush_dvalid", {63'd0, d_valid}, 64'd0);
    chk("t5_flush_fready", {63'd0, f_ready}, 64'd0);
    cyc();
    flush = 1'b0; f_valid = 1'b0;
    #1;
    chk("t5_after_dvalid", {63'd0, d_valid}, 64'd0);
    chk("t5_after_fready", {63'd0, f_ready}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("t5_no_stale", {63'd0, d_valid}, 64'd0);
    end

    // reset mid-stream behaves like flush
    f_valid = 1'b1; f_data = 64'h88880002_88880001; f_pc = 64'h6000;
    d_ready = 1'b0;
    #1;
    cyc();
    f_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid_dvalid", {63'd0, d_valid}, 64'd0);
    chk("rst_mid_fready", {63'd0, f_ready}, 64'd0);
    cyc();
    rst = 1'b0; d_ready = 1'b1;
    #1;
    chk("rst_mid_lost", {63'd0, d_valid}, 64'd0);
    cyc();

`ifdef FETCH_SPLIT_PERF_EN
    rst = 1'b1; f_valid = 1'b0;
    #1;
    cyc();
    rst = 1'b0; d_ready = 1'b1;
    for (int c = 0; c < 10; c++) cyc();
    chk("perf_10", {32'd0, perf_bubble}, 64'd10);
    rst = 1'b1;
    #1;
    cyc();
    chk("perf_rst", {32'd0, perf_bubble}, 64'd0);
    rst = 1'b0;
    #1;
`endif

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
